// File: rtl/plugboard.sv
// Plugboard: input FIFO, runtime pair-swap table and issue/wait handshake to the rotor.
// Optional macro PLUGBOARD_LOWERCASE_EN folds lowercase data and config letters to uppercase.
`timescale 1ns/1ps
module plugboard #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_PAIRS  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_clr,
  input  logic       cfg_we,
  input  logic [7:0] cfg_a,
  input  logic [7:0] cfg_b,
  output logic       cfg_err,
  output logic [3:0] pair_cnt,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       rot_done,
  output logic       busy
);

  localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned N_LETTERS = 26;
  localparam logic [7:0]  CHAR_A    = 8'h41;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_t;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

`ifdef PLUGBOARD_LOWERCASE_EN
  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction
`endif

  // Case folding applied to both the data path and configuration letters.
  function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef PLUGBOARD_LOWERCASE_EN
    if (is_lower(c)) begin
      return c - 8'h20;
    end
`endif
    return c;
  endfunction

  state_t           state, state_nxt;
  logic [4:0]       map [N_LETTERS];
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, empty, push, pop;
  logic [7:0]       head_f, subst;
  logic [7:0]       ca, cb;
  logic [4:0]       ia, ib;
  logic             cfg_ok;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign busy     = !empty || (state != S_IDLE);

  // FIFO storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Substitution of the FIFO head using the current table.
  always_comb begin
    head_f = fold(fifo_mem[rd_ptr]);
    subst  = head_f;
    if (is_upper(head_f)) begin
      subst = 8'(map[5'(head_f - CHAR_A)]) + CHAR_A;
    end
  end

  // Pair-write qualification.
  always_comb begin
    ca     = fold(cfg_a);
    cb     = fold(cfg_b);
    ia     = 5'(ca - CHAR_A);
    ib     = 5'(cb - CHAR_A);
    cfg_ok = 1'b0;
    if (is_upper(ca) && is_upper(cb) && (ca != cb)) begin
      cfg_ok = (map[ia] == ia) && (map[ib] == ib) &&
               (pair_cnt < 4'(MAX_PAIRS)) && !busy;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_LETTERS; i++) begin
        map[5'(i)] <= 5'(i);
      end
      pair_cnt <= '0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      if (cfg_clr) begin
        for (int unsigned i = 0; i < N_LETTERS; i++) begin
          map[5'(i)] <= 5'(i);
        end
        pair_cnt <= '0;
      end else if (cfg_we) begin
        if (cfg_ok) begin
          map[ia]  <= ib;
          map[ib]  <= ia;
          pair_cnt <= pair_cnt + 4'd1;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (rot_done) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered rotor-facing outputs: valid pulse tracks ISSUE, data held through WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      out_valid <= (state_nxt == S_ISSUE);
      if (pop) begin
        out_data <= subst;
      end
    end
  end

endmodule

// File: tb/tb_plugboard.sv
// Self-checking bench for plugboard: config vector table, scoreboard on rotor-side outputs.
`timescale 1ns/1ps
module tb_plugboard;

`ifdef PLUGBOARD_LOWERCASE_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_clr, cfg_we;
  logic [7:0] cfg_a, cfg_b;
  logic       cfg_err;
  logic [3:0] pair_cnt;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       rot_done;
  logic       busy;

  plugboard #(.FIFO_DEPTH(4), .MAX_PAIRS(10)) dut (
    .clk(clk), .reset(reset),
    .cfg_clr(cfg_clr), .cfg_we(cfg_we), .cfg_a(cfg_a), .cfg_b(cfg_b),
    .cfg_err(cfg_err), .pair_cnt(pair_cnt),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .rot_done(rot_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       exp_err;
    logic [3:0] exp_cnt;
  } cfg_vec_t;

  cfg_vec_t   vecs[$];
  logic [7:0] sb[$];
  logic [7:0] mon_exp;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         ov_count = 0;
  bit         rot_hold = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Scoreboard: every out_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (out_valid) begin
      ov_count++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got 0x%0h, no output expected", out_data);
      end else begin
        mon_exp = sb.pop_front();
        check("out_data", 32'(out_data), 32'(mon_exp));
      end
    end
  end

  // Rotor model: answers each pulse with a one-cycle done two cycles later unless held.
  initial begin
    rot_done = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        repeat (2) @(negedge clk);
        while (rot_hold) @(negedge clk);
        rot_done = 1'b1;
        @(negedge clk);
        rot_done = 1'b0;
      end
    end
  end

  task automatic push(input logic [7:0] d, input logic [7:0] exp);
    int k;
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back(exp);
    k = 0;
    while (!in_ready && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push_str(input string s, input string e);
    for (int i = 0; i < s.len(); i++) begin
      push(s[i], e[i]);
    end
  endtask

  task automatic cfg_write(input string nm, input logic [7:0] a, input logic [7:0] b,
                           input logic exp_err, input logic [3:0] exp_cnt);
    cfg_we = 1'b1;
    cfg_a  = a;
    cfg_b  = b;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check({nm, "_err"}, 32'(cfg_err), 32'(exp_err));
    check({nm, "_cnt"}, 32'(pair_cnt), 32'(exp_cnt));
    @(posedge clk); #1;
    check({nm, "_err_pulse"}, 32'(cfg_err), 32'd0);
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while ((sb.size() != 0 || busy) && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    check({nm, "_pending"}, 32'(sb.size()), 32'd0);
    check({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    vecs.push_back('{8'h41, 8'h5A, 1'b0, 4'd1});  // A-Z
    vecs.push_back('{8'h45, 8'h51, 1'b0, 4'd2});  // E-Q
    vecs.push_back('{8'h41, 8'h5A, 1'b1, 4'd2});  // A-Z again
    vecs.push_back('{8'h41, 8'h41, 1'b1, 4'd2});  // A-A
    vecs.push_back('{8'h31, 8'h42, 1'b1, 4'd2});  // '1'-B
    vecs.push_back('{8'h5A, 8'h43, 1'b1, 4'd2});  // Z already paired
    vecs.push_back('{8'h42, 8'h43, 1'b0, 4'd3});  // B-C
    vecs.push_back('{8'h44, 8'h46, 1'b0, 4'd4});  // D-F
    vecs.push_back('{8'h47, 8'h48, 1'b0, 4'd5});  // G-H
    vecs.push_back('{8'h49, 8'h4A, 1'b0, 4'd6});  // I-J
    vecs.push_back('{8'h4B, 8'h4C, 1'b0, 4'd7});  // K-L
    vecs.push_back('{8'h4D, 8'h4E, 1'b0, 4'd8});  // M-N
    vecs.push_back('{8'h4F, 8'h50, 1'b0, 4'd9});  // O-P
    vecs.push_back('{8'h52, 8'h53, 1'b0, 4'd10}); // R-S
    vecs.push_back('{8'h54, 8'h55, 1'b1, 4'd10}); // 11th pair

    reset = 1'b1; cfg_clr = 1'b0; cfg_we = 1'b0; cfg_a = 8'h00; cfg_b = 8'h00;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_pair_cnt", 32'(pair_cnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Identity path with first-character latency.
    push(8'h48, 8'h48);
    check("lat_edge_n", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_edge_n1", 32'(out_valid), 32'd1);
    push_str("ELLO", "ELLO");
    wait_drain("hello");
    check("hello_pair_cnt", 32'(pair_cnt), 32'd0);

    for (int i = 0; i < 2; i++) begin
      cfg_write($sformatf("cfg%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_err, vecs[i].exp_cnt);
    end
    push_str("AEZQB", "ZQAEB");
    wait_drain("swap");

    // Config write while busy is rejected.
    rot_hold = 1'b1;
    push(8'h4B, 8'h4B);
    cfg_write("cfg_busy", 8'h43, 8'h44, 1'b1, 4'd2);
    rot_hold = 1'b0;
    wait_drain("busy_rej");

    for (int i = 2; i < vecs.size(); i++) begin
      cfg_write($sformatf("cfg%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_err, vecs[i].exp_cnt);
    end
    push_str("ABCDEFGHIJKLMNOPQRSTUVWXYZ", "ZCBFQDHGJILKNMPOESRTUVWXYA");
    wait_drain("alpha");

    // Clear wins over a simultaneous write, without an error pulse.
    cfg_clr = 1'b1; cfg_we = 1'b1; cfg_a = 8'h58; cfg_b = 8'h59;
    @(posedge clk); #1;
    cfg_clr = 1'b0; cfg_we = 1'b0;
    check("clr_err", 32'(cfg_err), 32'd0);
    check("clr_cnt", 32'(pair_cnt), 32'd0);
    push_str("AZEQXY", "AZEQXY");
    wait_drain("clr_ident");

    // Backpressure: rotor stalled, FIFO fills, a held sixth byte is not lost.
    base = ov_count;
    rot_hold = 1'b1;
    push_str("VWXYZ", "VWXYZ");
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    fork
      push(8'h21, 8'h21);
      begin
        repeat (4) @(posedge clk);
        #1;
        check("bp_still_full", 32'(in_ready), 32'd0);
        check("bp_one_issued", 32'(ov_count - base), 32'd1);
        rot_hold = 1'b0;
      end
    join
    wait_drain("bp");
    check("bp_count", 32'(ov_count - base), 32'd6);

    // Reset during WAIT with two entries queued.
    cfg_write("cfg_mn", 8'h4D, 8'h4E, 1'b0, 4'd1);
    rot_hold = 1'b1;
    push_str("ABC", "ABC");
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    sb.delete();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'h00);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_pair_cnt", 32'(pair_cnt), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    base = ov_count;
    rot_hold = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_no_out", 32'(ov_count - base), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    push_str("MN", "MN");
    wait_drain("post_rst_ident");

    // Non-letters and lowercase handling.
    cfg_write("cfg_lower", 8'h61, 8'h7A, LC ? 1'b0 : 1'b1, LC ? 4'd1 : 4'd0);
    push_str(" a9", LC ? " Z9" : " a9");
    wait_drain("nonletter");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plugboard.md
# plugboard

Input-side letter-swap stage of the enigma datapath, directly upstream of the rotor. It accepts ASCII characters from the host through a small FIFO and applies a runtime-programmable reciprocal pair-swap table. It hands each result to the rotor as a one-cycle `valid` pulse with the byte on `din`, then waits for the rotor's `done` before issuing the next character.

## Interface
- `FIFO_DEPTH`, 4: input FIFO entries; power of two, ≥2.
- `MAX_PAIRS`, 10: maximum simultaneous swap pairs; 1..13.

- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cfg_clr`  in  1  restore identity table.
- `cfg_we`  in  1  write one swap pair.
- `cfg_a`, `cfg_b`  in  8 each  ASCII letters to pair.
- `cfg_err`  out  1  one-cycle pulse: last `cfg_we` rejected.
- `pair_cnt`  out  4  pairs currently installed.
- `in_valid`  in  1  host character valid.
- `in_data`  in  8  host ASCII character.
- `in_ready`  out  1  FIFO not full.
- `out_valid`  out  1  one-cycle pulse to rotor `valid`.
- `out_data`  out  8  substituted character to rotor `din`.
- `rot_done`  in  1  rotor `done`.
- `busy`  out  1  FIFO non-empty or FSM not in IDLE.

## Operation
- **Table**
  - 26 entries, 5 bits each: `map[i]`.
  - Reset and `cfg_clr` set `map[i]=i` and `pair_cnt=0` in one edge.
- **Pair write (`cfg_we`)**
  - Accepted only if all of these hold: both bytes in 0x41..0x5A; `cfg_a`≠`cfg_b`; both letters currently self-mapped; `pair_cnt`<MAX_PAIRS; `busy`=0.
  - On accept: `map[a]=b`, `map[b]=a`, `pair_cnt++`.
  - On reject: table unchanged; `cfg_err`=1 for the following cycle.
  - `cfg_clr` has priority over a simultaneous `cfg_we`; the `cfg_we` is dropped with no `cfg_err`.
- **Input**
  - Push when `in_valid && in_ready`.
  - `in_ready = !full`, combinational from occupancy.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
- **Substitution**
  - Head byte in 0x41..0x5A: output `map[c-0x41]+0x41`.
  - Any other byte: passed through unchanged.
- **FSM: IDLE → ISSUE → WAIT → IDLE**
  - IDLE: if FIFO is non-empty, pop the head and register `out_data`; next state ISSUE.
  - ISSUE: `out_valid`=1 for exactly this cycle; next state WAIT.
  - WAIT: hold `out_data`; on `rot_done`=1 go to IDLE. No timeout.
  - `rot_done` is ignored outside WAIT.

## Timing
- **Reset values:** `out_valid`=0, `out_data`=0x00, `cfg_err`=0, `pair_cnt`=0, `busy`=0, `in_ready`=1, FIFO empty, FSM in IDLE.
- **Latency:** character pushed at edge N → FSM enters ISSUE at edge N+1 → `out_valid` high from N+1 to N+2.
- **Throughput:** after `rot_done` is sampled at edge M, IDLE at M, the next ISSUE at M+1. Minimum spacing between `out_valid` pulses is 3 cycles plus the rotor latency.
- **Table timing:** lookup uses the table value at the IDLE edge. Table writes cannot occur while `busy`=1, so mid-stream edits are impossible.
- **Reset mid-operation:** FIFO flushed, FSM forced to IDLE, table back to identity. A pending `rot_done` after reset is ignored.
- **Full boundary:** at FIFO_DEPTH entries `in_ready`=0; a held `in_valid` is not lost and pushes on the first cycle `in_ready` returns to 1.

## Configuration
- Macro `PLUGBOARD_LOWERCASE_EN`.
- **Defined:**
  - FIFO input bytes 0x61..0x7A are folded to uppercase (−0x20) before lookup; output is uppercase.
  - `cfg_a`/`cfg_b` also accept lowercase, folded the same way.
- **Undefined:** lowercase bytes pass through unchanged, and lowercase config bytes are rejected with `cfg_err`.

## Test plan
- **Identity:** after reset, push "HELLO" and answer each `out_valid` with `rot_done` 2 cycles later → `out_data` sequence 0x48,0x45,0x4C,0x4C,0x4F; `pair_cnt`=0.
- **Swap:** write pairs A↔Z and E↔Q, then push "AEZQB" → outputs 'Z','Q','A','E','B'; `pair_cnt`=2.
- **Config rejects:** each of the following gives a `cfg_err` pulse and no change to `pair_cnt`:
  - A↔Z again after it is installed;
  - A↔A;
  - '1'↔B;
  - an 11th pair when MAX_PAIRS=10;
  - any `cfg_we` with `busy`=1.
- **Backpressure:** hold `rot_done` low and push 5 bytes continuously.
  - `in_ready` falls once 4 entries are held, with one character parked in WAIT.
  - After `rot_done` is released, all 5 characters emerge in order with no loss.
- **Reset mid-stream:** assert `reset` during WAIT with 2 entries queued → all outputs at reset values, table is identity, and no `out_valid` follows.
- **Non-letter and macro check:** push " a9" → without the macro, 0x20,0x61,0x39; with `PLUGBOARD_LOWERCASE_EN` and A↔Z installed, 0x20,'Z',0x39.
